// File: rtl/rtc_bus_scheduler.sv
// Multiplexed-bus RTC scheduler: periodic nine-register read bursts plus user writes.
// Optional macro RTC_POST_WRITE_REFRESH_EN: a completed write also requests a fresh burst.
module rtc_bus_scheduler #(
  parameter int T_PHASE     = 10,
  parameter int REFRESH_DIV = 2500000
) (
  input  logic       CLK_NX,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] year,
  output logic [7:0] scrono,
  output logic [7:0] mcrono,
  output logic [7:0] hcrono,
  output logic       wr_ack,
  output logic       burst_done,
  output logic       busy
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, GAP1, DATA, GAP2} state_t;

  state_t          state;
  state_t          state_nx;
  logic [7:0]      phase_cnt;
  logic [RW-1:0]   refresh_cnt;
  logic            refresh_pending;
  logic            burst_active;
  logic [3:0]      burst_idx;
  logic            is_write;
  logic            a_d_q;
  logic [7:0]      cur_addr;
  logic [7:0]      wr_data_q;
  logic [8:0][7:0] staging;

  logic       phase_last;
  logic       boundary;
  logic       txn_end;
  logic       write_done;
  logic       read_end;
  logic       burst_last;
  logic       refresh_wrap;
  logic       post_write_set;
  logic       pending_now;
  logic       cont_burst;
  logic       start_write;
  logic       start_new_burst;
  logic       start_resume;
  logic       start_any;
  logic [3:0] next_idx;

  function automatic logic [7:0] burst_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    burst_addr = 8'h21;
      4'd1:    burst_addr = 8'h22;
      4'd2:    burst_addr = 8'h23;
      4'd3:    burst_addr = 8'h24;
      4'd4:    burst_addr = 8'h25;
      4'd5:    burst_addr = 8'h26;
      4'd6:    burst_addr = 8'h41;
      4'd7:    burst_addr = 8'h42;
      4'd8:    burst_addr = 8'h43;
      default: burst_addr = 8'h21;
    endcase
  endfunction

  assign phase_last   = (phase_cnt == 8'(T_PHASE - 1));
  assign txn_end      = (state == GAP2) && phase_last;
  assign boundary     = (state == IDLE) || txn_end;
  assign write_done   = txn_end && is_write;
  assign read_end     = txn_end && !is_write;
  assign burst_last   = read_end && (burst_idx == 4'd8);
  assign refresh_wrap = (refresh_cnt == RW'(REFRESH_DIV - 1));

`ifdef RTC_POST_WRITE_REFRESH_EN
  assign post_write_set = write_done;
`else
  assign post_write_set = 1'b0;
`endif

  // A write finishing this cycle must be visible to the arbitration happening on the same edge.
  assign pending_now     = refresh_pending | post_write_set;
  assign cont_burst      = burst_active && !burst_last;
  assign start_write     = boundary && wr_req;
  assign start_resume    = boundary && !wr_req && cont_burst;
  assign start_new_burst = boundary && !wr_req && !cont_burst && pending_now;
  assign start_any       = start_write | start_resume | start_new_burst;
  assign next_idx        = burst_last ? 4'd0 : (read_end ? burst_idx + 4'd1 : burst_idx);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start_any) state_nx = ADDR;
      ADDR: if (phase_last) state_nx = GAP1;
      GAP1: if (phase_last) state_nx = DATA;
      DATA: if (phase_last) state_nx = GAP2;
      GAP2: if (phase_last) state_nx = start_any ? ADDR : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK_NX) begin
    if (reset) begin
      state           <= IDLE;
      phase_cnt       <= 8'd0;
      refresh_cnt     <= '0;
      refresh_pending <= 1'b1;
      burst_active    <= 1'b0;
      burst_idx       <= 4'd0;
      is_write        <= 1'b0;
      a_d_q           <= 1'b0;
      cur_addr        <= 8'd0;
      wr_data_q       <= 8'd0;
      staging         <= '0;
    end else begin
      state     <= state_nx;
      phase_cnt <= (state == IDLE || phase_last) ? 8'd0 : phase_cnt + 8'd1;
      burst_idx <= next_idx;

      if (state == ADDR) a_d_q <= 1'b0;
      else if (state == DATA) a_d_q <= 1'b1;

      refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + RW'(1);

      // A wrap coinciding with a burst start still counts as a new request.
      if (refresh_wrap) refresh_pending <= 1'b1;
      else if (start_new_burst) refresh_pending <= 1'b0;
      else if (post_write_set) refresh_pending <= 1'b1;

      if (start_new_burst) burst_active <= 1'b1;
      else if (burst_last) burst_active <= 1'b0;

      if (start_write) begin
        is_write  <= 1'b1;
        cur_addr  <= wr_addr;
        wr_data_q <= wr_data;
      end else if (start_new_burst || start_resume) begin
        is_write <= 1'b0;
        cur_addr <= burst_addr(next_idx);
      end

      if (state == DATA && phase_last && !is_write) staging[burst_idx] <= ad_in;
    end
  end

  always_ff @(posedge CLK_NX) begin
    if (reset) begin
      seg    <= 8'd0;
      min    <= 8'd0;
      hora   <= 8'd0;
      dia    <= 8'd0;
      mes    <= 8'd0;
      year   <= 8'd0;
      scrono <= 8'd0;
      mcrono <= 8'd0;
      hcrono <= 8'd0;
    end else if (burst_last) begin
      seg    <= staging[0];
      min    <= staging[1];
      hora   <= staging[2];
      dia    <= staging[3];
      mes    <= staging[4];
      year   <= staging[5];
      scrono <= staging[6];
      mcrono <= staging[7];
      hcrono <= staging[8];
    end
  end

  // Bus strobes decode straight from the state register so reset releases the bus on its edge.
  assign busy       = (state != IDLE);
  assign wr_ack     = write_done;
  assign burst_done = burst_last;
  assign cs_n       = !((state == ADDR) || (state == DATA));
  assign rd_n       = !((state == DATA) && !is_write);
  assign wr_n       = !((state == ADDR) || ((state == DATA) && is_write));
  assign ad_oe      = (state == ADDR) || ((state == DATA) && is_write);
  assign ad_out     = (state == ADDR) ? cur_addr :
                      ((state == DATA) && is_write) ? wr_data_q : 8'd0;
  assign a_d        = (state == ADDR) ? 1'b0 : (state == DATA) ? 1'b1 : a_d_q;

endmodule

// File: doc/rtc_bus_scheduler.md
RTC_BUS_SCHEDULER -- requirements
Module: rtc_bus_scheduler

Interface
REQ-001 Parameter T_PHASE, default 10: clock cycles per bus phase; legal range 2..255.
REQ-002 Parameter REFRESH_DIV, default 2500000: clock cycles between periodic read bursts; legal range ≥ 100.
REQ-003 CLK_NX  in  1  system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 wr_req  in  1  user write request; held high until wr_ack.
REQ-006 wr_addr  in  8  RTC register address to write.
REQ-007 wr_data  in  8  value to write.
REQ-008 ad_in  in  8  RTC multiplexed bus, read direction.
REQ-009 ad_out  out  8  RTC multiplexed bus, drive direction.
REQ-010 ad_oe  out  1  bus drive enable; 1 = block drives ad_out.
REQ-011 cs_n, rd_n, wr_n, a_d  out  1 each  RTC chip select, read strobe, write strobe, address/data select (0 = address).
REQ-012 seg, min, hora, dia, mes, year, scrono, mcrono, hcrono  out  8 each  shadow copies of RTC registers.
REQ-013 wr_ack  out  1  one-cycle pulse when a write completes.
REQ-014 burst_done  out  1  one-cycle pulse when the shadow registers update.
REQ-015 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-016 FSM states: IDLE, ADDR, GAP1, DATA, GAP2; each non-IDLE state lasts exactly T_PHASE cycles; one transaction is 4*T_PHASE cycles.
REQ-017 ADDR: cs_n=0, wr_n=0, a_d=0, ad_oe=1, ad_out=address.
REQ-018 GAP1/GAP2: cs_n=rd_n=wr_n=1, ad_oe=0; a_d holds its previous value.
REQ-019 Read DATA: cs_n=0, rd_n=0, a_d=1, ad_oe=0; ad_in is sampled on the last cycle of DATA into a staging register.
REQ-020 Write DATA: cs_n=0, wr_n=0, a_d=1, ad_oe=1, ad_out=latched wr_data.
REQ-021 Read burst: 9 transactions in fixed order 0x21 seg, 0x22 min, 0x23 hora, 0x24 dia, 0x25 mes, 0x26 year, 0x41 scrono, 0x42 mcrono, 0x43 hcrono.
REQ-022 All nine shadow outputs load from staging in the same cycle at the end of the last GAP2; burst_done pulses in that cycle; shadow outputs never change at any other time.
REQ-023 Refresh counter runs 0..REFRESH_DIV-1 and wraps; at wrap it sets refresh_pending; a wrap while refresh_pending is already set is coalesced, not queued.
REQ-024 Arbitration happens at IDLE and at every transaction boundary (end of GAP2); a pending wr_req beats the next read transaction.
REQ-025 A write preempts a burst only between transactions; the burst then resumes at the next index and is not restarted.
REQ-026 wr_addr and wr_data are latched on the cycle the write is accepted; later input changes do not affect it.
REQ-027 wr_ack pulses on the last GAP2 cycle of the write; if wr_req is still high on the following cycle, it is treated as a new request.
REQ-028 If wr_req drops before acceptance, it is ignored; once accepted, the write always completes.
REQ-029 From IDLE with work pending, ADDR begins on the next cycle.
REQ-030 refresh_pending clears when the burst's first transaction starts; it is not cleared when the burst ends.

Reset
REQ-031 On reset: state IDLE, cs_n=rd_n=wr_n=1, a_d=0, ad_oe=0, ad_out=0, all shadow and staging registers 0, wr_ack=burst_done=busy=0, refresh counter 0, burst index 0.
REQ-032 On reset, refresh_pending is set to 1, so the first burst starts on the first cycle after reset release.
REQ-033 Reset asserted mid-transaction aborts it; the bus is released on that same clock edge; no wr_ack or burst_done is issued.

Configuration
REQ-034 Macro RTC_POST_WRITE_REFRESH_EN defined: completion of any write sets refresh_pending, so a fresh burst follows the write.
REQ-035 Macro undefined: writes do not affect refresh_pending; bursts come only from reset and the refresh counter.

Verification (T_PHASE=2, REFRESH_DIV=200, bus model returns data = address)
REQ-036 Reset release, no writes -> first ADDR next cycle, ad_out=0x21; burst_done at cycle 72; seg=0x21, min=0x22, ..., hcrono=0x43 all change in that cycle.
REQ-037 Idle, wr_req with 0x22/0x59 -> ADDR cycles 1-2 (ad_out=0x22, a_d=0, wr_n=0); DATA cycles 5-6 (ad_out=0x59, a_d=1); wr_ack at cycle 8; busy high throughout.
REQ-038 wr_req raised during transaction 3 (hora) -> the write runs immediately after that transaction; the burst resumes at 0x24; shadows stay unchanged until burst_done.
REQ-039 Two refresh wraps during one burst -> exactly one additional burst follows.
REQ-040 Reset during a read DATA phase -> next cycle cs_n=rd_n=wr_n=1, ad_oe=0, all shadows 0, no burst_done pulse.
REQ-041 Scenario of REQ-037 with the macro defined -> read ADDR (0x21) on the cycle after wr_ack; macro undefined -> no ADDR until the next refresh wrap.
